// File: rtl/i2s_msb_transmitter.sv
// I2S MSB-first transmitter: reads 256-bit frames bit-serially from a circular
// channel buffer and shifts them out on the falling edges of an external bit clock.
module i2s_msb_transmitter #(
  parameter int unsigned CIRC_BUF_BITS = 3
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       enable_i,
  input  logic                       frame_valid_i,
  input  logic                       i2s_bclk_i,
  output logic [CIRC_BUF_BITS+7:0]   ram_read_addr_o,
  input  logic                       ram_read_data_i,
  output logic                       i2s_data_o,
  output logic                       i2s_ws_o,
  output logic                       i2s_running_o,
  output logic                       underrun_o,
  output logic                       overflow_o
);

  typedef enum logic [1:0] {IDLE, PREFETCH, SHIFT} state_t;

  localparam logic [CIRC_BUF_BITS:0] PEND_FULL = {1'b1, {CIRC_BUF_BITS{1'b0}}};

  state_t                    r_state;
  logic                      r_bclk_meta;
  logic                      r_bclk_sync;
  logic                      r_bclk_prev;
  logic [7:0]                r_bit_cnt;
  logic [CIRC_BUF_BITS-1:0]  r_rd_idx;
  logic [CIRC_BUF_BITS:0]    r_pending;
  logic [CIRC_BUF_BITS+7:0]  r_addr;
  logic [1:0]                r_pf_wait;
  logic                      r_prefetch;
  logic                      r_zero_slot;
  logic                      r_last;
  logic                      r_data;
  logic                      r_ws;
  logic                      r_running;
  logic                      r_underrun;
  logic                      r_overflow;

  logic                      w_bclk_fall;
  logic                      w_pend_nz;
  logic                      w_pend_full;
  logic                      w_slot_end;
  logic                      w_consume;
  logic [CIRC_BUF_BITS-1:0]  w_rd_idx_next;

  assign w_bclk_fall   = r_bclk_prev & ~r_bclk_sync;
  assign w_pend_nz     = (r_pending != '0);
  assign w_pend_full   = (r_pending == PEND_FULL);
  assign w_slot_end    = (r_state == SHIFT) && w_bclk_fall && !r_last && (r_bit_cnt == 8'd255);
  assign w_consume     = enable_i && w_pend_nz &&
                         ((r_state == IDLE) || w_slot_end);
  // A zero-filled underrun slot does not own a buffer frame, so it leaves rd_idx alone.
  assign w_rd_idx_next = r_zero_slot ? r_rd_idx : r_rd_idx + 1'b1;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_bclk_meta <= 1'b0;
      r_bclk_sync <= 1'b0;
      r_bclk_prev <= 1'b0;
    end else begin
      r_bclk_meta <= i2s_bclk_i;
      r_bclk_sync <= r_bclk_meta;
      r_bclk_prev <= r_bclk_sync;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_pending  <= '0;
      r_overflow <= 1'b0;
    end else if (frame_valid_i && !w_consume) begin
      if (w_pend_full) r_overflow <= 1'b1;
      else             r_pending  <= r_pending + 1'b1;
    end else if (!frame_valid_i && w_consume) begin
      r_pending <= r_pending - 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state     <= IDLE;
      r_bit_cnt   <= '0;
      r_rd_idx    <= '0;
      r_addr      <= '0;
      r_pf_wait   <= '0;
      r_prefetch  <= 1'b0;
      r_zero_slot <= 1'b0;
      r_last      <= 1'b0;
      r_data      <= 1'b0;
      r_ws        <= 1'b0;
      r_running   <= 1'b0;
      r_underrun  <= 1'b0;
    end else begin
      // The address is stable for many clk cycles between bclk edges, so the
      // one-cycle RAM latency is absorbed by capturing read data every cycle.
      r_prefetch <= ram_read_data_i;
      case (r_state)
        IDLE: begin
          r_bit_cnt   <= '0;
          r_addr      <= {r_rd_idx, 8'd0};
          r_zero_slot <= 1'b0;
          r_last      <= 1'b0;
          r_pf_wait   <= '0;
          if (enable_i && w_pend_nz) r_state <= PREFETCH;
        end
        PREFETCH: begin
          r_pf_wait <= r_pf_wait + 1'b1;
          if (r_pf_wait == 2'd2) r_state <= SHIFT;
        end
        SHIFT: begin
          if (w_bclk_fall) begin
            if (r_last) begin
              r_data    <= 1'b0;
              r_ws      <= 1'b0;
              r_running <= 1'b0;
              r_bit_cnt <= '0;
              r_last    <= 1'b0;
              r_state   <= IDLE;
            end else begin
              r_data    <= r_zero_slot ? 1'b0 : r_prefetch;
              r_ws      <= ~r_bit_cnt[7];
              r_running <= 1'b1;
              r_bit_cnt <= r_bit_cnt + 1'b1;
              if (r_bit_cnt != 8'd255) begin
                if (!r_zero_slot) r_addr <= {r_rd_idx, r_bit_cnt + 8'd1};
              end else begin
                r_rd_idx <= w_rd_idx_next;
                r_addr   <= {w_rd_idx_next, 8'd0};
                if (!enable_i) begin
                  r_last      <= 1'b1;
                  r_zero_slot <= 1'b0;
                end else if (w_pend_nz) begin
                  r_zero_slot <= 1'b0;
                end else begin
                  r_zero_slot <= 1'b1;
                  r_underrun  <= 1'b1;
                end
              end
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign ram_read_addr_o = r_addr;
  assign i2s_data_o      = r_data;
  assign i2s_ws_o        = r_ws;
  assign i2s_running_o   = r_running;
  assign underrun_o      = r_underrun;
  assign overflow_o      = r_overflow;

endmodule

// File: tb/tb_i2s_msb_transmitter.sv
// Bench for i2s_msb_transmitter: a behavioural buffer RAM feeds the DUT and a
// bclk-rising-edge monitor pops expected {ws,data} pairs from a scoreboard queue.
module tb_i2s_msb_transmitter;

  localparam int unsigned CBB = 3;
  localparam int unsigned AW  = CBB + 8;

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b1;
  logic          enable_i = 1'b0;
  logic          frame_valid_i = 1'b0;
  logic          i2s_bclk_i = 1'b0;
  logic [AW-1:0] ram_read_addr_o;
  logic          ram_read_data_i = 1'b0;
  logic          i2s_data_o;
  logic          i2s_ws_o;
  logic          i2s_running_o;
  logic          underrun_o;
  logic          overflow_o;

  int n_checks = 0;
  int n_fail   = 0;

  logic       mem [0:2047];
  logic [1:0] exp_q [$];
  logic [1:0] mon_e;

  i2s_msb_transmitter #(.CIRC_BUF_BITS(CBB)) dut (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .enable_i        (enable_i),
    .frame_valid_i   (frame_valid_i),
    .i2s_bclk_i      (i2s_bclk_i),
    .ram_read_addr_o (ram_read_addr_o),
    .ram_read_data_i (ram_read_data_i),
    .i2s_data_o      (i2s_data_o),
    .i2s_ws_o        (i2s_ws_o),
    .i2s_running_o   (i2s_running_o),
    .underrun_o      (underrun_o),
    .overflow_o      (overflow_o)
  );

  initial forever #5 clk_i = ~clk_i;
  // 90 ns bclk period (9 clk) with an offset that keeps its edges off clk edges.
  initial begin
    #2;
    forever #45 i2s_bclk_i = ~i2s_bclk_i;
  end

  always @(posedge clk_i) ram_read_data_i <= mem[ram_read_addr_o];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  always @(posedge i2s_bclk_i) begin
    if (!rst_i && i2s_running_o) begin
      if (exp_q.size() == 0) begin
        check_eq("extra_bit", exp_q.size(), 1);
      end else begin
        mon_e = exp_q.pop_front();
        check_eq("ws", i2s_ws_o, mon_e[1]);
        check_eq("data", i2s_data_o, mon_e[0]);
      end
    end
  end

  task automatic push_frame(input int k, input bit zero);
    for (int b = 0; b < 256; b++)
      exp_q.push_back({(b < 128) ? 1'b1 : 1'b0, zero ? 1'b0 : mem[k*256 + b]});
  endtask

  task automatic pulse_fv(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk_i); #1 frame_valid_i = 1'b1;
      @(posedge clk_i); #1 frame_valid_i = 1'b0;
    end
  endtask

  task automatic wait_q(input int n, input int limit, input string tag);
    int cnt = 0;
    while (exp_q.size() > n && cnt < limit) begin
      @(posedge clk_i);
      cnt++;
    end
    check_eq({"reach_", tag}, (exp_q.size() <= n) ? 32'd1 : 32'd0, 1);
  endtask

  task automatic check_idle(input string tag);
    repeat (2) @(negedge i2s_bclk_i);
    repeat (5) @(posedge clk_i);
    #1;
    check_eq({tag, "_running"}, i2s_running_o, 0);
    check_eq({tag, "_data"}, i2s_data_o, 0);
    check_eq({tag, "_ws"}, i2s_ws_o, 0);
    check_eq({tag, "_qempty"}, exp_q.size(), 0);
  endtask

  task automatic do_reset(input string tag);
    @(posedge clk_i); #2 rst_i = 1'b1;
    #1;
    check_eq({tag, "_data"}, i2s_data_o, 0);
    check_eq({tag, "_ws"}, i2s_ws_o, 0);
    check_eq({tag, "_running"}, i2s_running_o, 0);
    check_eq({tag, "_underrun"}, underrun_o, 0);
    check_eq({tag, "_overflow"}, overflow_o, 0);
    check_eq({tag, "_addr"}, ram_read_addr_o, 0);
    exp_q.delete();
    enable_i = 1'b0;
    frame_valid_i = 1'b0;
    repeat (3) @(posedge clk_i);
    #1 rst_i = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 2048; i++) mem[i] = 1'($urandom_range(0, 1));

    // Power-on reset.
    do_reset("rst0");

    // Eight full frames streamed back to back.
    pulse_fv(8);
    for (int k = 0; k < 8; k++) push_frame(k, 1'b0);
    enable_i = 1'b1;
    wait_q(200, 25000, "frame7");
    enable_i = 1'b0;
    wait_q(0, 3000, "stream_done");
    check_idle("stream_end");
    check_eq("stream_underrun", underrun_o, 0);
    check_eq("stream_overflow", overflow_o, 0);

    // Nine pulses with no transmission saturate the pending count.
    pulse_fv(9);
    check_eq("ovf_flag", overflow_o, 1);
    check_eq("ovf_pending", dut.r_pending, 8);
    // Pulse coincident with the IDLE consumption: count stays at 8.
    push_frame(0, 1'b0);
    @(posedge clk_i); #1 enable_i = 1'b1; frame_valid_i = 1'b1;
    @(posedge clk_i); #1 frame_valid_i = 1'b0;
    check_eq("coinc_pending", dut.r_pending, 8);
    wait_q(250, 4000, "coinc_start");
    enable_i = 1'b0;
    wait_q(0, 4000, "coinc_done");
    check_idle("coinc_end");
    check_eq("ovf_sticky", overflow_o, 1);

    // Enable dropped at bit 100 must not truncate the frame.
    do_reset("rst1");
    pulse_fv(1);
    push_frame(0, 1'b0);
    enable_i = 1'b1;
    wait_q(156, 4000, "bit100");
    enable_i = 1'b0;
    wait_q(0, 4000, "trunc_done");
    check_idle("trunc_end");
    check_eq("trunc_underrun", underrun_o, 0);

    // Single frame with enable held: frame 0 then a zero-filled slot.
    do_reset("rst2");
    pulse_fv(1);
    push_frame(0, 1'b0);
    push_frame(0, 1'b1);
    enable_i = 1'b1;
    wait_q(300, 4000, "pre_underrun");
    check_eq("underrun_before", underrun_o, 0);
    wait_q(256, 1000, "frame0_end");
    check_eq("underrun_after", underrun_o, 1);
    wait_q(200, 1000, "zero_slot");
    enable_i = 1'b0;
    wait_q(0, 4000, "zero_done");
    check_idle("zero_end");
    check_eq("underrun_sticky", underrun_o, 1);
    // The zero slot did not advance rd_idx, so the next frame is frame 1.
    pulse_fv(1);
    push_frame(1, 1'b0);
    enable_i = 1'b1;
    wait_q(200, 4000, "f1_start");
    enable_i = 1'b0;
    wait_q(0, 4000, "f1_done");
    check_idle("f1_end");

    // Reset at bit 50 of frame 3 aborts everything; restart at address 0.
    do_reset("rst3");
    pulse_fv(4);
    for (int k = 0; k < 4; k++) push_frame(k, 1'b0);
    enable_i = 1'b1;
    wait_q(206, 12000, "f3_bit49");
    @(negedge i2s_bclk_i);
    repeat (5) @(posedge clk_i);
    check_eq("f3_running", i2s_running_o, 1);
    do_reset("abort");
    check_eq("abort_pending", dut.r_pending, 0);
    pulse_fv(1);
    push_frame(0, 1'b0);
    enable_i = 1'b1;
    wait_q(150, 4000, "restart");
    enable_i = 1'b0;
    wait_q(0, 4000, "restart_done");
    check_idle("restart_end");
    check_eq("restart_underrun", underrun_o, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
